// File: rtl/game_frame_sequencer.sv
// Screen/game-state sequencer: tracks lives from hit pulses and commits screen
// changes only on vsync_tick so the colorizer never switches mid-frame.
module game_frame_sequencer #(
    parameter int unsigned LIVES    = 3,
    parameter int unsigned LIFE_W   = 2,
    parameter int unsigned WIN_HOLD = 300,
    parameter int unsigned HOLD_W   = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync_tick,
    input  logic              start_btn,
    input  logic              tank_hit,
    input  logic              train_hit,
    output logic              frame1,
    output logic              frame2,
    output logic              frame3,
    output logic              frame4,
    output logic [LIFE_W-1:0] tank_lives,
    output logic [LIFE_W-1:0] train_lives,
    output logic              game_active
);

    typedef enum logic [1:0] {
        ST_TITLE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_TANK_WIN  = 2'd2,
        ST_TRAIN_WIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    state_e              req_state_q, req_state_d;
    logic                req_valid_q, req_valid_d;
    logic                start_q;
    logic                start_rise;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [LIFE_W-1:0]   tank_lives_q, tank_lives_d;
    logic [LIFE_W-1:0]   train_lives_q, train_lives_d;
    logic [3:0]          frame_q, frame_d;
    logic                game_active_q, game_active_d;

    assign start_rise = start_btn & ~start_q;

    // Event detection raises a request; vsync_tick commits the (possibly new) request.
    always_comb begin
        state_d       = state_q;
        req_state_d   = req_state_q;
        req_valid_d   = req_valid_q;
        hold_d        = hold_q;
        tank_lives_d  = tank_lives_q;
        train_lives_d = train_lives_q;

        case (state_q)
            ST_TITLE: begin
                if (start_rise) begin
                    req_valid_d = 1'b1;
                    req_state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!req_valid_q) begin
                    if (tank_hit && (tank_lives_q != '0))
                        tank_lives_d = tank_lives_q - LIFE_W'(1);
                    if (train_hit && (train_lives_q != '0))
                        train_lives_d = train_lives_q - LIFE_W'(1);
                    if ((tank_lives_d == '0) && (train_lives_d == '0)) begin
                        req_valid_d = 1'b1;
                        req_state_d = ST_TITLE;
                    end else if (train_lives_d == '0) begin
                        req_valid_d = 1'b1;
                        req_state_d = ST_TANK_WIN;
                    end else if (tank_lives_d == '0) begin
                        req_valid_d = 1'b1;
                        req_state_d = ST_TRAIN_WIN;
                    end
                end
            end
            ST_TANK_WIN, ST_TRAIN_WIN: begin
                if (vsync_tick && (hold_q != HOLD_W'(WIN_HOLD)))
                    hold_d = hold_q + HOLD_W'(1);
                if (!req_valid_q && (start_rise || (hold_q == HOLD_W'(WIN_HOLD)))) begin
                    req_valid_d = 1'b1;
                    req_state_d = ST_TITLE;
                end
            end
            default: ;
        endcase

        if (vsync_tick && req_valid_d) begin
            state_d     = req_state_d;
            req_valid_d = 1'b0;
            hold_d      = '0;
            if (req_state_d == ST_PLAY) begin
                tank_lives_d  = LIFE_W'(LIVES);
                train_lives_d = LIFE_W'(LIVES);
            end
        end
    end

    // Screen selects decoded from the next state so they line up with state_q.
    always_comb begin
        frame_d = 4'b0000;
        case (state_d)
            ST_TITLE:     frame_d = 4'b0001;
            ST_PLAY:      frame_d = 4'b0010;
            ST_TANK_WIN:  frame_d = 4'b0100;
            ST_TRAIN_WIN: frame_d = 4'b1000;
            default:      frame_d = 4'b0001;
        endcase
        game_active_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_TITLE;
            req_state_q   <= ST_TITLE;
            req_valid_q   <= 1'b0;
            start_q       <= 1'b0;
            hold_q        <= '0;
            tank_lives_q  <= LIFE_W'(LIVES);
            train_lives_q <= LIFE_W'(LIVES);
            frame_q       <= 4'b0001;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_state_q   <= req_state_d;
            req_valid_q   <= req_valid_d;
            start_q       <= start_btn;
            hold_q        <= hold_d;
            tank_lives_q  <= tank_lives_d;
            train_lives_q <= train_lives_d;
            frame_q       <= frame_d;
            game_active_q <= game_active_d;
        end
    end

    assign frame1      = frame_q[0];
    assign frame2      = frame_q[1];
    assign frame3      = frame_q[2];
    assign frame4      = frame_q[3];
    assign tank_lives  = tank_lives_q;
    assign train_lives = train_lives_q;
    assign game_active = game_active_q;

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Scenario bench for game_frame_sequencer: expected screen/lives vectors are
// queued as stimulus is driven and compared once the DUT has clocked it.
module tb_game_frame_sequencer;

    localparam logic [3:0] F_TITLE = 4'b0001;
    localparam logic [3:0] F_PLAY  = 4'b0010;
    localparam logic [3:0] F_TWIN  = 4'b0100;
    localparam logic [3:0] F_RWIN  = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vsync_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       tank_hit = 1'b0;
    logic       train_hit = 1'b0;
    logic       frame1, frame2, frame3, frame4;
    logic [1:0] tank_lives, train_lives;
    logic       game_active;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {frame4..frame1, tank_lives, train_lives, game_active}
    logic [8:0] exp_q[$];
    logic [8:0] obs;
    logic [8:0] expv;

    game_frame_sequencer #(
        .LIVES(3), .LIFE_W(2), .WIN_HOLD(4), .HOLD_W(9)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vsync_tick(vsync_tick),
        .start_btn(start_btn), .tank_hit(tank_hit), .train_hit(train_hit),
        .frame1(frame1), .frame2(frame2), .frame3(frame3), .frame4(frame4),
        .tank_lives(tank_lives), .train_lives(train_lives),
        .game_active(game_active)
    );

    always #5 clk = ~clk;

    assign obs = {frame4, frame3, frame2, frame1, tank_lives, train_lives, game_active};

    function automatic logic [8:0] mk(input logic [3:0] f, input logic [1:0] tl, input logic [1:0] rl);
        return {f, tl, rl, (f == F_PLAY)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            vsync_tick = (c % 100 == 50);
            exp_q.push_back(mk(F_TITLE, 2'd3, 2'd3));
            cycle();
            expv = exp_q.pop_front();
            if (c % 100 == 50 || c == 0) begin
                total_cnt++;
                if (obs !== expv) $display("FAIL reset_idle c=%0d got=%b want=%b", c, obs, expv);
                else pass_cnt++;
            end
        end
        vsync_tick = 1'b0;
    endtask

    task automatic test_start();
        repeat (10) cycle();
        start_btn = 1'b1;
        for (int c = 10; c < 50; c++) cycle();
        total_cnt++;
        if (obs !== mk(F_TITLE, 2'd3, 2'd3)) $display("FAIL start_prevsync got=%b want=%b", obs, mk(F_TITLE, 2'd3, 2'd3));
        else pass_cnt++;
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_PLAY, 2'd3, 2'd3));
        cycle();
        vsync_tick = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL start_commit got=%b want=%b", obs, expv);
        else pass_cnt++;
        for (int c = 0; c < 200; c++) begin
            vsync_tick = (c % 20 == 7);
            exp_q.push_back(mk(F_PLAY, 2'd3, 2'd3));
            cycle();
            expv = exp_q.pop_front();
            if (vsync_tick) begin
                total_cnt++;
                if (obs !== expv) $display("FAIL start_held c=%0d got=%b want=%b", c, obs, expv);
                else pass_cnt++;
            end
        end
        vsync_tick = 1'b0;
        start_btn  = 1'b0;
        cycle();
    endtask

    task automatic test_tank_win();
        for (int h = 0; h < 3; h++) begin
            train_hit = 1'b1;
            exp_q.push_back(mk(F_PLAY, 2'd3, 2'(2 - h)));
            cycle();
            train_hit = 1'b0;
            cycle();
            expv = exp_q.pop_front();
            total_cnt++;
            if (obs !== expv) $display("FAIL train_hit_%0d got=%b want=%b", h, obs, expv);
            else pass_cnt++;
        end
        train_hit = 1'b1;
        tank_hit  = 1'b1;
        exp_q.push_back(mk(F_PLAY, 2'd3, 2'd0));
        cycle();
        train_hit = 1'b0;
        tank_hit  = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL hit_after_zero got=%b want=%b", obs, expv);
        else pass_cnt++;
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_TWIN, 2'd3, 2'd0));
        cycle();
        vsync_tick = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL tank_win got=%b want=%b", obs, expv);
        else pass_cnt++;
        // Start rise and vsync in the same cycle commit together.
        start_btn  = 1'b1;
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_TITLE, 2'd3, 2'd0));
        cycle();
        vsync_tick = 1'b0;
        start_btn  = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL twin_to_title got=%b want=%b", obs, expv);
        else pass_cnt++;
        cycle();
    endtask

    task automatic enter_play();
        start_btn = 1'b0;
        cycle();
        start_btn = 1'b1;
        cycle();
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_PLAY, 2'd3, 2'd3));
        cycle();
        vsync_tick = 1'b0;
        start_btn  = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL enter_play got=%b want=%b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic test_draw();
        enter_play();
        for (int h = 0; h < 3; h++) begin
            tank_hit  = 1'b1;
            train_hit = 1'b1;
            exp_q.push_back(mk(F_PLAY, 2'(2 - h), 2'(2 - h)));
            cycle();
            tank_hit  = 1'b0;
            train_hit = 1'b0;
            expv = exp_q.pop_front();
            total_cnt++;
            if (obs !== expv) $display("FAIL draw_hit_%0d got=%b want=%b", h, obs, expv);
            else pass_cnt++;
        end
        repeat (3) cycle();
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_TITLE, 2'd0, 2'd0));
        cycle();
        vsync_tick = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL draw_title got=%b want=%b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic kill_tank();
        for (int h = 0; h < 3; h++) begin
            tank_hit = 1'b1;
            cycle();
            tank_hit = 1'b0;
            cycle();
        end
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_RWIN, 2'd0, 2'd3));
        cycle();
        vsync_tick = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL train_win got=%b want=%b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic test_win_hold();
        enter_play();
        kill_tank();
        for (int t = 1; t <= 5; t++) begin
            repeat (4) cycle();
            vsync_tick = 1'b1;
            exp_q.push_back(mk((t <= 4) ? F_RWIN : F_TITLE, 2'd0, 2'd3));
            cycle();
            vsync_tick = 1'b0;
            expv = exp_q.pop_front();
            total_cnt++;
            if (obs !== expv) $display("FAIL hold_tick_%0d got=%b want=%b", t, obs, expv);
            else pass_cnt++;
        end
        enter_play();
        kill_tank();
        for (int t = 1; t <= 2; t++) begin
            repeat (4) cycle();
            vsync_tick = 1'b1;
            exp_q.push_back(mk((t == 1) ? F_RWIN : F_TITLE, 2'd0, 2'd3));
            cycle();
            vsync_tick = 1'b0;
            expv = exp_q.pop_front();
            total_cnt++;
            if (obs !== expv) $display("FAIL early_start_tick_%0d got=%b want=%b", t, obs, expv);
            else pass_cnt++;
            if (t == 1) start_btn = 1'b1;
        end
        start_btn = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_game();
        enter_play();
        for (int h = 0; h < 2; h++) begin
            tank_hit = 1'b1;
            cycle();
            tank_hit = 1'b0;
        end
        total_cnt++;
        if (obs !== mk(F_PLAY, 2'd1, 2'd3)) $display("FAIL pre_reset got=%b want=%b", obs, mk(F_PLAY, 2'd1, 2'd3));
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== mk(F_TITLE, 2'd3, 2'd3)) $display("FAIL async_reset got=%b want=%b", obs, mk(F_TITLE, 2'd3, 2'd3));
        else pass_cnt++;
        repeat (3) cycle();
        reset_n = 1'b1;
        repeat (2) cycle();
        vsync_tick = 1'b1;
        exp_q.push_back(mk(F_TITLE, 2'd3, 2'd3));
        cycle();
        vsync_tick = 1'b0;
        expv = exp_q.pop_front();
        total_cnt++;
        if (obs !== expv) $display("FAIL post_reset_vsync got=%b want=%b", obs, expv);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_tank_win();
        test_draw();
        test_win_hold();
        test_reset_mid_game();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/game_frame_sequencer.md
Name: game_frame_sequencer

Overview:
- Top-level screen/game-state controller sitting directly upstream of the colorizer.
- Drives the one-hot screen selects frame1 (title), frame2 (map/play), frame3 (tank win) and frame4 (train win).
- Tracks remaining lives for both players from bullet-hit pulses.
- Commits screen changes only at vertical-blank boundaries so the display never switches mid-frame.

Parameters:
- LIVES, 3, hits each player can absorb; reload value at game start (1..2^LIFE_W-1).
- LIFE_W, 2, width of each lives counter.
- WIN_HOLD, 300, vsync_tick count a win screen is held before auto-return to title (~5 s at 60 Hz).
- HOLD_W, 9, width of the win-hold counter; must hold WIN_HOLD.

Ports:
- clk  in  1  system pixel-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync_tick  in  1  single-cycle pulse at start of vertical blank.
- start_btn  in  1  debounced start/restart level; rising edge detected internally.
- tank_hit  in  1  single-cycle pulse: a train bullet hit the tank.
- train_hit  in  1  single-cycle pulse: a tank bullet hit the train.
- frame1  out  1  title screen select.
- frame2  out  1  play screen select.
- frame3  out  1  tank-win screen select.
- frame4  out  1  train-win screen select.
- tank_lives  out  LIFE_W  remaining tank lives.
- train_lives  out  LIFE_W  remaining train lives.
- game_active  out  1  high exactly while frame2 is high.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - state TITLE: frame1=1, frame2/3/4=0.
  - tank_lives=train_lives=LIVES.
  - game_active=0.
  - hold counter 0, pending request NONE, start edge register 0.
- Outputs: all registered. frame1..4 are a function of state only and are always exactly one-hot.
- States and screen selects: TITLE→frame1, PLAY→frame2, TANK_WIN→frame3, TRAIN_WIN→frame4.
- Start edge: start_rise = start_btn & ~start_q, with start_q registered every cycle.
- Pending request register, set by events and held until commit:
  - TITLE: start_rise → request PLAY.
  - PLAY, train_lives reaches 0 → request TANK_WIN.
  - PLAY, tank_lives reaches 0 → request TRAIN_WIN.
  - PLAY, both reach 0 in the same cycle → request TITLE (draw).
  - TANK_WIN/TRAIN_WIN: start_rise, or hold counter == WIN_HOLD → request TITLE.
- Commit:
  - On any edge where vsync_tick=1, state ← request, and the request clears.
  - A request raised in the same cycle as vsync_tick commits on that edge.
  - Latency from event to frame output change is therefore 1 cycle to next vsync_tick inclusive.
  - vsync_tick with no request: state unchanged.
- Lives:
  - In PLAY with no exit request pending: tank_hit decrements tank_lives and train_hit decrements train_lives, each saturating at 0. Both may decrement in the same cycle.
  - Hits in any other state, or while an exit request is pending, are ignored.
  - Lives reload to LIVES on the edge that commits PLAY.
  - Lives hold their values through the win screens so they remain displayable.
- Hold counter:
  - Cleared on entry to any state.
  - In win states, increments on each vsync_tick and saturates at WIN_HOLD.
  - Frozen in other states.
- Multiple requests before commit: once a request is pending, later events in the same state do not change it. Exception: a start_rise in TITLE is idempotent.
- Reset mid-game: async return to TITLE with lives reloaded; any pending request is discarded.

Test Plan:
- Reset release, no stimulus → frame1=1, frame2..4=0, tank_lives=train_lives=3, game_active=0 for 1000 cycles including vsync_ticks.
- start_btn rises at cycle 10, vsync_tick at cycle 50 → frame1 stays 1 through cycle 50; frame2=1 and game_active=1 from cycle 51; start held high for 200 cycles causes no further transition.
- PLAY, three train_hit pulses, then vsync_tick → train_lives 3→2→1→0; frame3=1 after the vsync edge; a 4th train_hit and any tank_hit pulses leave train_lives=0 and tank_lives unchanged.
- PLAY with both lives=1, tank_hit and train_hit in the same cycle, then vsync_tick → both lives 0, state returns to TITLE (frame1=1), not a win screen.
- TRAIN_WIN, WIN_HOLD=4, no start → frame4 held for exactly 4 vsync_ticks, frame1=1 after the 5th tick; repeat with start_rise after tick 1 → frame1=1 after tick 2.
- PLAY with tank_lives=1, reset_n asserted for 3 cycles mid-frame → frame1=1 immediately (asynchronous), lives=3; a subsequent vsync_tick with no start stays in TITLE.
